// File: rtl/rx_array_loader.sv
// UART (8N1) receiver that assembles NU*WIDTH-bit initial-condition arrays for the solver.
// Optional trailing XOR checksum byte is enabled with `define RX_CHECKSUM_EN.
module rx_array_loader #(
  parameter int NU           = 10,
  parameter int WIDTH        = 32,
  parameter int CLKS_PER_BIT = 347,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                  clk40mhz,
  input  logic                  reset,
  input  logic                  RX,
  output logic [NU*WIDTH-1:0]   u_Load,
  output logic                  load_valid,
  output logic                  busy,
  output logic                  frame_err
);

  localparam int NBYTES = NU * WIDTH / 8;
`ifdef RX_CHECKSUM_EN
  localparam int FRAME_BYTES = NBYTES + 1;
`else
  localparam int FRAME_BYTES = NBYTES;
`endif
  localparam int BCW       = $clog2(FRAME_BYTES + 1);
  localparam int CW        = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES + 1);

  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic                 rx_meta, rx_sync, rx_prev;
  logic [1:0]           sync_vld;
  logic                 armed;
  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [7:0]           shift;
  logic [BCW-1:0]       byte_cnt;
  logic [NU*WIDTH-1:0]  shadow;
  logic [NU*WIDTH-1:0]  shadow_next;
  logic [TW-1:0]        to_cnt;
  logic                 fall;
  logic                 tick;
  logic                 last_byte;
  logic                 to_hit;
`ifdef RX_CHECKSUM_EN
  logic [7:0]           chk;
`endif

  // Edges are only trusted once the line has been seen high after reset.
  assign fall      = armed && rx_prev && !rx_sync;
  assign tick      = (cnt == CW'(1));
  assign last_byte = (byte_cnt == BCW'(FRAME_BYTES - 1));
  assign to_hit    = busy && (state == S_IDLE) && (to_cnt == TW'(TO_CYCLES - 1));

  always_comb begin
    shadow_next = shadow;
    if (int'(byte_cnt) < NBYTES) begin
      shadow_next[int'(byte_cnt)*8 +: 8] = shift;
    end else begin
      shadow_next = shadow;
    end
  end

  always_ff @(posedge clk40mhz) begin
    if (reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      sync_vld   <= 2'b00;
      armed      <= 1'b0;
      state      <= S_IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'h00;
      byte_cnt   <= '0;
      shadow     <= '0;
      u_Load     <= '0;
      load_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
`ifdef RX_CHECKSUM_EN
      chk        <= 8'h00;
`endif
    end else begin
      rx_meta    <= RX;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      sync_vld   <= {sync_vld[0], 1'b1};
      if (sync_vld[1] && rx_sync) begin
        armed <= 1'b1;
      end else begin
        armed <= armed;
      end
      load_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fall) begin
            state <= S_START;
            cnt   <= HALF;
          end else if (to_hit) begin
            byte_cnt <= '0;
            busy     <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_START: begin
          if (!tick) begin
            cnt <= cnt - CW'(1);
          end else if (!rx_sync) begin
            state   <= S_DATA;
            cnt     <= FULL;
            bit_idx <= 3'd0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (tick) begin
            shift   <= {rx_sync, shift[7:1]};
            cnt     <= FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              state <= S_DATA;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (!tick) begin
            cnt <= cnt - CW'(1);
          end else if (!rx_sync) begin
            // Bad stop bit throws away the whole frame, not just this byte.
            state     <= S_IDLE;
            frame_err <= 1'b1;
            byte_cnt  <= '0;
            busy      <= 1'b0;
          end else if (last_byte) begin
            state    <= S_IDLE;
            byte_cnt <= '0;
            busy     <= 1'b0;
`ifdef RX_CHECKSUM_EN
            if (shift == chk) begin
              u_Load     <= shadow;
              load_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
`else
            u_Load     <= shadow_next;
            load_valid <= 1'b1;
`endif
          end else begin
            state    <= S_IDLE;
            byte_cnt <= byte_cnt + BCW'(1);
            busy     <= 1'b1;
            shadow   <= shadow_next;
`ifdef RX_CHECKSUM_EN
            if (byte_cnt == '0) begin
              chk <= shift;
            end else begin
              chk <= chk ^ shift;
            end
`endif
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Idle-time watchdog for partially received frames.
  always_ff @(posedge clk40mhz) begin
    if (reset) begin
      to_cnt <= '0;
    end else if (!busy || state != S_IDLE || fall || to_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_rx_array_loader.sv
// Directed bench for rx_array_loader with a frame-level behavioural model and per-cycle monitor.
// Honours `define RX_CHECKSUM_EN to append and check the XOR checksum byte.
module tb_rx_array_loader;
  localparam int NU = 2;
  localparam int WIDTH = 16;
  localparam int CPB = 8;
  localparam int TOB = 20;
  localparam int NB = NU * WIDTH / 8;

  logic clk40mhz = 1'b0;
  logic reset;
  logic RX;
  logic [NU*WIDTH-1:0] u_Load;
  logic load_valid, busy, frame_err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  frame_bytes[$];
  logic [31:0] exp_loads[$];
  int          err_pending = 0;
  logic [31:0] held = 32'h0;

  rx_array_loader #(.NU(NU), .WIDTH(WIDTH), .CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk40mhz(clk40mhz), .reset(reset), .RX(RX), .u_Load(u_Load),
    .load_valid(load_valid), .busy(busy), .frame_err(frame_err));

  always #5 clk40mhz = ~clk40mhz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: frame of bytes -> expected array value or expected error.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    logic [31:0] v;
    logic [7:0]  x;
    int          flen;
    flen = NB;
`ifdef RX_CHECKSUM_EN
    flen = NB + 1;
`endif
    if (!stop_ok) begin
      err_pending++;
      frame_bytes.delete();
    end else begin
      frame_bytes.push_back(b);
      if (frame_bytes.size() == flen) begin
        v = 32'h0;
        x = 8'h00;
        for (int i = 0; i < NB; i++) begin
          v = v | (32'(frame_bytes[i]) << (8 * i));
          x = x ^ frame_bytes[i];
        end
        if (flen == NB || frame_bytes[NB] == x) exp_loads.push_back(v);
        else err_pending++;
        frame_bytes.delete();
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    RX = 1'b0;
    repeat (CPB) @(negedge clk40mhz);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clk40mhz);
    end
    RX = stop_ok;
    repeat (CPB) @(negedge clk40mhz);
    RX = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3);
    send_byte(b0, 1'b1);
    check("busy_after_first", {63'd0, busy}, 64'd1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
`ifdef RX_CHECKSUM_EN
    check("busy_before_chk", {63'd0, busy}, 64'd1);
    send_byte(b0 ^ b1 ^ b2 ^ b3, 1'b1);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk40mhz);
  endtask

  task automatic checkpoint(input string name);
    idle(4);
    check({name, "_busy"}, {63'd0, busy}, {63'd0, frame_bytes.size() != 0});
    check({name, "_load_missing"}, 64'(exp_loads.size()), 64'd0);
    check({name, "_err_missing"}, 64'(err_pending), 64'd0);
  endtask

  // Per-cycle compare of the DUT against the model's expectations.
  always @(posedge clk40mhz) begin
    #1;
    if (load_valid) begin
      if (exp_loads.size() == 0) begin
        check("unexpected_load_valid", 64'd1, 64'd0);
      end else begin
        held = exp_loads.pop_front();
        check("u_Load_on_valid", 64'(u_Load), 64'(held));
      end
    end else begin
      check("u_Load_hold", 64'(u_Load), 64'(held));
    end
    if (frame_err) begin
      if (err_pending == 0) check("unexpected_frame_err", 64'd1, 64'd0);
      else err_pending--;
    end
  end

  initial begin
    RX = 1'b1;
    reset = 1'b1;
    idle(5);
    check("rst_u_Load", 64'(u_Load), 64'd0);
    check("rst_load_valid", {63'd0, load_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_frame_err", {63'd0, frame_err}, 64'd0);
    reset = 1'b0;
    idle(10);

    // Basic frame.
    send_frame(8'h34, 8'h12, 8'h78, 8'h56);
    check("busy_after_frame", {63'd0, busy}, 64'd0);
    checkpoint("frame1");
    check("lit_frame1", 64'(u_Load), 64'h56781234);

    // Bad stop bit on second byte aborts the frame.
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b0);
    idle(10);
    checkpoint("stop_err");
    send_frame(8'h11, 8'h22, 8'h33, 8'h44);
    checkpoint("after_err");
    check("lit_after_err", 64'(u_Load), 64'h44332211);

    // Partial frame timed out.
    send_byte(8'hAA, 1'b1);
    check("busy_partial", {63'd0, busy}, 64'd1);
    idle(200);
    frame_bytes.delete();
    check("busy_timeout", {63'd0, busy}, 64'd0);
    send_frame(8'h01, 8'h02, 8'h03, 8'h04);
    checkpoint("timeout");
    check("lit_timeout", 64'(u_Load), 64'h04030201);

    // Short glitch is ignored.
    RX = 1'b0;
    idle(3);
    RX = 1'b1;
    idle(100);
    checkpoint("glitch");

    // Reset mid-way through the third byte.
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    RX = 1'b0;
    idle(CPB);
    RX = 1'b1;
    idle(CPB);
    RX = 1'b0;
    idle(CPB);
    reset = 1'b1;
    RX = 1'b1;
    frame_bytes.delete();
    held = 32'h0;
    idle(2);
    check("midrst_u_Load", 64'(u_Load), 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    idle(20);
    send_frame(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    checkpoint("post_reset");
    check("lit_post_reset", 64'(u_Load), 64'hDEADBEEF);

`ifdef RX_CHECKSUM_EN
    // Wrong checksum keeps the previous array.
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h09, 1'b1);
    checkpoint("bad_chk");
    check("lit_bad_chk", 64'(u_Load), 64'hDEADBEEF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rx_array_loader.md
# rx_array_loader

UART receive stage that feeds the 1D finite-difference solver. It deserialises bytes arriving on `RX` into a full `NU*WIDTH`-bit initial-condition array and presents it with a one-cycle `load_valid` strobe. The top level copies that array into the solver's state register and starts a calculation run. It sits directly upstream of the Jacobi iteration / `u_Array` register and uses the same packing as the transmit path.

## Interface
- `NU`, 10: number of array elements.
- `WIDTH`, 32: bits per element; must be a multiple of 8.
- `CLKS_PER_BIT`, 347: `clk40mhz` cycles per UART bit (115200 baud); minimum 4.
- `TIMEOUT_BITS`, 20: idle bit-times after which a partial frame is discarded.

Ports:
- `clk40mhz`  in  1: sole clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `RX`  in  1: asynchronous UART line, idle high, 8N1, LSB first.
- `u_Load`  out  NU*WIDTH: last completed array; element k at bits `[k*WIDTH +: WIDTH]`.
- `load_valid`  out  1: one-cycle strobe; `u_Load` is new this cycle.
- `busy`  out  1: high while a frame is partially received.
- `frame_err`  out  1: one-cycle strobe on a bad stop bit, or on checksum mismatch when checksum is compiled in.

## Operation
- `RX` passes through a 2-FF synchroniser, reset to 1.
- Bit FSM:
  - IDLE: a 1→0 transition on the synchronised line goes to START and loads the bit counter with `CLKS_PER_BIT/2`.
  - START: at counter expiry, resample. If low, go to DATA; if high, the start was a glitch: return to IDLE with no error.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 samples, shifted LSB first.
  - STOP: sample once more. High: byte accepted, go to IDLE. Low: `frame_err` pulse, the whole frame is aborted (byte count := 0), go to IDLE.
- Byte assembly:
  - A frame is `NU*WIDTH/8` data bytes.
  - Byte index b lands in shadow bits `[b*8 +: 8]`, so elements are little-endian and element 0 arrives first.
  - The shadow register is internal. `u_Load` is never partially updated.
- On the final accepted data byte, `u_Load` := shadow, `load_valid` = 1 for one cycle, byte count := 0, `busy` := 0.
- `busy` is 1 from the first accepted byte of a frame until completion, abort or timeout.
- Timeout: while `busy` and the FSM is in IDLE, count cycles. After `TIMEOUT_BITS*CLKS_PER_BIT` cycles, discard the partial frame (byte count := 0, `busy` := 0). Timeout raises no error strobe. The counter clears on every start bit.
- `reset` at any point: FSM := IDLE, counters := 0, `busy` = 0, `load_valid` = 0, `frame_err` = 0, `u_Load` = 0, shadow = 0. A byte in flight during reset is lost. The receiver resynchronises on the next falling edge seen after `RX` has returned high.

## Timing
- Reset values of outputs: `u_Load` = 0, `load_valid` = 0, `busy` = 0, `frame_err` = 0.
- Synchroniser latency: 2 cycles.
- Data sample points: mid-bit, `CLKS_PER_BIT/2 + n*CLKS_PER_BIT` cycles after the synchronised falling edge, n = 1..8. Stop-bit sample at n = 9.
- `load_valid` and the `u_Load` update occur in the cycle immediately after the final stop-bit sample (or checksum stop-bit sample).
- `frame_err` asserts the cycle after the failing sample.
- There is no back-pressure. The consumer must capture `u_Load` on `load_valid`; `u_Load` holds its value until the next completed frame.
- A new start bit may arrive immediately after a stop bit; there is no dead time.

## Configuration
- `RX_CHECKSUM_EN` defined:
  - One extra byte follows the data bytes, equal to the XOR of all data bytes.
  - Match: `load_valid` and `u_Load` update as above.
  - Mismatch: `frame_err` pulses, `u_Load` is unchanged, no `load_valid`.
  - `busy` stays high through the checksum byte.
- `RX_CHECKSUM_EN` undefined: no checksum byte; completion occurs on the last data byte.

## Test plan
All scenarios use NU=2, WIDTH=16, CLKS_PER_BIT=8, TIMEOUT_BITS=20.
- Reset, then send 0x34,0x12,0x78,0x56 (plus checksum 0x08 if enabled) → one `load_valid` pulse; `u_Load`=0x56781234; `busy` falls the same cycle.
- Send 0x34,0x12 with the second byte's stop bit forced low → `frame_err` pulse; `busy`=0; a following valid 4-byte frame loads correctly.
- Send 0xAA, idle 200 cycles, then 0x01,0x02,0x03,0x04 → first byte dropped silently; `u_Load`=0x04030201.
- Drive a 3-cycle low glitch on `RX` → no byte accepted, `busy`=0, no `frame_err`.
- Assert `reset` mid-way through the third byte of a frame → all outputs 0; the next full frame loads correctly.
- With `RX_CHECKSUM_EN`, send 0x34,0x12,0x78,0x56,0x09 → `frame_err` pulse; `u_Load` retains its previous value; no `load_valid`.
